// File: rtl/cache_addr_unit.sv
// Cache address decode unit.
// Splits a request address into tag / set index / word offset and emits either
// a single lookup beat or a critical-word-first block-refill burst of
// 2**OFFSET_W beats over a valid/ready output channel.
module cache_addr_unit #(
  parameter  int ADDR_W   = 32,
  parameter  int INDEX_W  = 6,
  parameter  int OFFSET_W = 2,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_fill,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [INDEX_W-1:0]  out_index,
  output logic [OFFSET_W-1:0] out_offset,
  output logic                out_last,
  output logic                busy
);

  localparam int                BEATS    = 1 << OFFSET_W;
  // Beat counter value on the final beat of a burst.
  localparam logic [OFFSET_W:0] LAST_CNT = (OFFSET_W + 1)'(BEATS - 1);

  // A zero-width tag would leave nothing to compare in the tag store.
  generate
    if (TAG_W < 1) begin : g_bad_tag_w
      $error("cache_addr_unit: TAG_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [OFFSET_W:0]   cnt_q, cnt_d;
  logic                accept;
  logic                burst_done;

  assign accept     = req_valid & req_ready;
  assign burst_done = (cnt_q == LAST_CNT);

  assign out_valid  = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign out_tag    = tag_q;
  assign out_index  = index_q;
  assign out_offset = offset_q;
  assign out_last   = (state_q == SINGLE) | ((state_q == BURST) & burst_done);

  // Request-side ready: free in IDLE, lookups pipeline through SINGLE, bursts block.
  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      SINGLE:  req_ready = out_ready;
      default: req_ready = 1'b0;
    endcase
  end

  // Next-state logic: retire/advance the held beat, then load any accepted request.
  // An accept in SINGLE implies out_ready, so loading after the retire gives the
  // no-bubble lookup-to-lookup path for free.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;

    case (state_q)
      SINGLE: begin
        if (out_ready) state_d = IDLE;
      end
      BURST: begin
        if (out_ready) begin
          if (burst_done) begin
            state_d = IDLE;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            offset_d = offset_q + 1'b1;  // natural wrap modulo 2**OFFSET_W
          end
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d  = req_fill ? BURST : SINGLE;
      tag_d    = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
      index_d  = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
      offset_d = req_addr[OFFSET_W-1:0];
      cnt_d    = '0;
    end
  end

  // State and field registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_addr_unit.sv
// Testbench for cache_addr_unit: directed scenarios plus randomized traffic
// checked against a beat-queue reference model, and a wide-parameter instance.
module tb_cache_addr_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  // Default-parameter instance (32/6/2)
  logic        req_valid, req_ready, req_fill;
  logic [31:0] req_addr;
  logic        out_valid, out_ready, out_last, busy;
  logic [23:0] out_tag;
  logic [5:0]  out_index;
  logic [1:0]  out_offset;

  // Wide instance (40/8/3)
  logic        s_req_valid, s_req_ready, s_req_fill;
  logic [39:0] s_req_addr;
  logic        s_out_valid, s_out_ready, s_out_last, s_busy;
  logic [28:0] s_out_tag;
  logic [7:0]  s_out_index;
  logic [2:0]  s_out_offset;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  cache_addr_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_fill(req_fill),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_index(out_index),
    .out_offset(out_offset), .out_last(out_last), .busy(busy)
  );

  cache_addr_unit #(.ADDR_W(40), .INDEX_W(8), .OFFSET_W(3)) u_sw (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr), .req_fill(s_req_fill),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_tag(s_out_tag), .out_index(s_out_index),
    .out_offset(s_out_offset), .out_last(s_out_last), .busy(s_busy)
  );

  typedef struct {
    logic [23:0] tag;
    logic [5:0]  idx;
    logic [1:0]  off;
    bit          last;
    bit          burst;
  } beat_t;

  beat_t q[$];

  // Apply inputs for one cycle on the falling edge, then let combinational paths settle.
  task automatic drive(input logic v, input logic [31:0] a, input logic f, input logic r);
    @(negedge clk);
    req_valid = v; req_addr = a; req_fill = f; out_ready = r;
    #1;
  endtask

  task automatic drive_s(input logic v, input logic [39:0] a, input logic f, input logic r);
    @(negedge clk);
    s_req_valid = v; s_req_addr = a; s_req_fill = f; s_out_ready = r;
    #1;
  endtask

  task automatic test_reset();
    logic [33:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got = {out_valid, out_tag, out_index, out_offset, out_last};
    checks++;
    if (got !== 34'd0 || busy !== 1'b0 || s_out_valid !== 1'b0 || s_busy !== 1'b0)
      $display("FAIL reset_state: got fields=%h busy=%b s_valid=%b s_busy=%b, want all 0",
               got, busy, s_out_valid, s_busy);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || s_req_ready !== 1'b1)
      $display("FAIL reset_ready: got %b/%b want 1/1", req_ready, s_req_ready);
    else passes++;
    $display("reset: released, req_ready=%b", req_ready);
  endtask

  task automatic test_lookup();
    logic [33:0] got, exp;
    drive(1, 32'h123456AB, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL lookup_accept: got valid=%b ready=%b want 0/1", out_valid, req_ready);
    else passes++;
    drive(0, 32'h0, 0, 1);
    got = {out_valid, out_tag, out_index, out_offset, out_last};
    exp = {1'b1, 24'h123456, 6'h2A, 2'd3, 1'b1};
    checks++;
    if (got !== exp) $display("FAIL lookup_fields: got %h want %h", got, exp);
    else passes++;
    $display("lookup: addr=123456ab tag=%h idx=%h off=%0d last=%b", out_tag, out_index, out_offset, out_last);
    drive(0, 32'h0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL lookup_idle: got valid=%b busy=%b want 0/0", out_valid, busy);
    else passes++;
  endtask

  task automatic test_refill();
    int offs[4] = '{3, 0, 1, 2};
    logic [34:0] got, exp;
    drive(1, 32'h123456AB, 1, 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'h0, 0, 1);
      got = {out_valid, out_tag, out_index, out_offset, out_last, req_ready};
      exp = {1'b1, 24'h123456, 6'h2A, 2'(offs[k]), (k == 3), 1'b0};
      checks++;
      if (got !== exp) $display("FAIL refill_beat%0d: got %h want %h", k, got, exp);
      else passes++;
      $display("refill beat %0d: off=%0d last=%b ready=%b", k, out_offset, out_last, req_ready);
    end
    drive(0, 32'h0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL refill_end: got valid=%b ready=%b want 0/1", out_valid, req_ready);
    else passes++;
  endtask

  task automatic test_backpressure();
    int       offs[7] = '{3, 0, 0, 0, 0, 1, 2};
    bit       rdy[7]  = '{1, 0, 0, 0, 1, 1, 1};
    logic [33:0] got, exp;
    drive(1, 32'h123456AB, 1, 1);
    for (int c = 0; c < 7; c++) begin
      drive(0, 32'h0, 0, rdy[c]);
      got = {out_valid, out_tag, out_index, out_offset, out_last};
      exp = {1'b1, 24'h123456, 6'h2A, 2'(offs[c]), (c == 6)};
      checks++;
      if (got !== exp) $display("FAIL backpressure_c%0d: got %h want %h", c, got, exp);
      else passes++;
      $display("backpressure cycle %0d: out_ready=%b off=%0d last=%b", c, rdy[c], out_offset, out_last);
    end
    drive(0, 32'h0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL backpressure_end: got valid=%b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h00000004, 0, 1);
    drive(1, 32'h000000FC, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 6'h01 || out_offset !== 2'd0 || req_ready !== 1'b1)
      $display("FAIL b2b_first: got valid=%b idx=%h off=%0d ready=%b want 1/01/0/1",
               out_valid, out_index, out_offset, req_ready);
    else passes++;
    $display("b2b beat 1: idx=%h", out_index);
    drive(0, 32'h0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 6'h3F || out_offset !== 2'd0 || out_tag !== 24'h0)
      $display("FAIL b2b_second: got valid=%b idx=%h off=%0d tag=%h want 1/3f/0/0",
               out_valid, out_index, out_offset, out_tag);
    else passes++;
    $display("b2b beat 2: idx=%h", out_index);
    drive(0, 32'h0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_end: got valid=%b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_reset_mid_burst();
    logic [33:0] got, exp;
    drive(1, 32'h123456AB, 1, 1);
    drive(0, 32'h0, 0, 1);   // beat 1 taken
    drive(0, 32'h0, 0, 1);   // beat 2 taken
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {out_valid, out_tag, out_index, out_offset, out_last};
    checks++;
    if (got !== 34'd0 || busy !== 1'b0)
      $display("FAIL midburst_reset: got fields=%h busy=%b want 0/0", got, busy);
    else passes++;
    $display("reset mid-burst: valid=%b busy=%b", out_valid, busy);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h0BADF00D, 0, 1);
    drive(0, 32'h0, 0, 1);
    got = {out_valid, out_tag, out_index, out_offset, out_last};
    exp = {1'b1, 24'h0BADF0, 6'h03, 2'd1, 1'b1};
    checks++;
    if (got !== exp) $display("FAIL post_reset_lookup: got %h want %h", got, exp);
    else passes++;
    drive(0, 32'h0, 0, 1);
  endtask

  // Randomized traffic against a queue of outstanding beats.
  task automatic test_random();
    logic [31:0] a;
    logic        v, f, r, exp_valid, exp_ready;
    logic [33:0] got, exp;
    beat_t       b;
    int          nacc = 0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 3) != 0);
      a = $urandom;
      drive(v, a, f, r);
      exp_valid = (q.size() != 0);
      if (q.size() == 0)                      exp_ready = 1'b1;
      else if (q.size() == 1 && !q[0].burst)  exp_ready = r;
      else                                    exp_ready = 1'b0;
      checks++;
      if (out_valid !== exp_valid || busy !== exp_valid || req_ready !== exp_ready)
        $display("FAIL random_ctrl c%0d: got valid=%b busy=%b ready=%b want %b/%b/%b",
                 c, out_valid, busy, req_ready, exp_valid, exp_valid, exp_ready);
      else passes++;
      if (exp_valid) begin
        got = {out_valid, out_tag, out_index, out_offset, out_last};
        exp = {1'b1, q[0].tag, q[0].idx, q[0].off, q[0].last};
        checks++;
        if (got !== exp) $display("FAIL random_beat c%0d: got %h want %h", c, got, exp);
        else passes++;
      end
      // Clock edge: retire the head beat, then append the beats of an accepted request.
      if (exp_valid && r) void'(q.pop_front());
      if (v && exp_ready) begin
        nacc++;
        for (int k = 0; k < (f ? 4 : 1); k++) begin
          b.tag   = 24'(a / 256);
          b.idx   = 6'((a / 4) % 64);
          b.off   = 2'(((a % 4) + k) % 4);
          b.last  = f ? (k == 3) : 1'b1;
          b.burst = f;
          q.push_back(b);
        end
      end
    end
    $display("random: 400 cycles, %0d requests accepted", nacc);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b0;
    q.delete();
  endtask

  task automatic test_sweep();
    logic [39:0] a;
    logic [41:0] got, exp;
    a = {$urandom, $urandom};
    a[2:0] = 3'd7;
    drive_s(1, a, 1, 1);
    checks++;
    if (s_req_ready !== 1'b1 || s_out_valid !== 1'b0)
      $display("FAIL sweep_accept: got ready=%b valid=%b want 1/0", s_req_ready, s_out_valid);
    else passes++;
    for (int k = 0; k < 8; k++) begin
      drive_s(0, 40'h0, 0, 1);
      got = {s_out_valid, s_out_tag, s_out_index, s_out_offset, s_out_last};
      exp = {1'b1, 29'(a / 2048), 8'((a / 8) % 256), 3'((7 + k) % 8), (k == 7)};
      checks++;
      if (got !== exp) $display("FAIL sweep_beat%0d: got %h want %h", k, got, exp);
      else passes++;
      $display("sweep burst beat %0d: off=%0d last=%b", k, s_out_offset, s_out_last);
    end
    a = {$urandom, $urandom};
    drive_s(1, a, 0, 1);
    drive_s(0, 40'h0, 0, 1);
    got = {s_out_valid, s_out_tag, s_out_index, s_out_offset, s_out_last};
    exp = {1'b1, 29'(a / 2048), 8'((a / 8) % 256), 3'(a % 8), 1'b1};
    checks++;
    if (got !== exp) $display("FAIL sweep_lookup: got %h want %h", got, exp);
    else passes++;
    $display("sweep lookup: addr=%h tag=%h idx=%h off=%0d", a, s_out_tag, s_out_index, s_out_offset);
    drive_s(0, 40'h0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_fill = 1'b0; out_ready = 1'b0;
    s_req_valid = 1'b0; s_req_addr = '0; s_req_fill = 1'b0; s_out_ready = 1'b0;
    test_reset();
    test_lookup();
    test_refill();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
